wb_la_master: RTL and testbench

WB_LA_MASTER -- requirements
Module: wb_la_master

---
 rtl/wb_la_master_pkg.sv | 14 +
 rtl/wb_timeout_ctr.sv | 36 +++
 rtl/wb_la_master.sv | 114 +++++++++++
 tb/tb_wb_la_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_la_master_pkg.sv
// Shared definitions for the Wishbone local-access master.
//   state_t  : control FSM states (IDLE, BUS, RESP)
//   TO_CNT_W : width of the saturating bus-cycle timeout counter
package wb_la_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating timeout counter for one Wishbone bus cycle.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (asserted when a new bus cycle is launched)
//   enable   : count this cycle (high while the bus cycle is outstanding)
//   limit    : number of cycles allowed; 0 disables the timeout
//   expired  : this enabled cycle is the limit-th one, i.e. the count
//              reaches limit at the coming edge
module wb_timeout_ctr
  import wb_la_master_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [TO_CNT_W-1:0] limit,
  output logic                expired
);

  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W:0]   cnt_inc;

  // One bit wider so the compare also works when limit is the max value.
  assign cnt_inc = {1'b0, cnt_q} + {{TO_CNT_W{1'b0}}, 1'b1};
  assign expired = enable && (limit != '0) && (cnt_inc >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_inc[TO_CNT_W-1:0];
    end
  end

endmodule

// File: rtl/wb_la_master.sv
// Command/response front end driving a single Wishbone classic initiator.
// One command is accepted in IDLE, run as a single bus cycle in BUS, and
// its result presented in RESP until consumed.
//   wb_clk_i, wb_rst_i         : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake (we, adr, dat, sel)
//   rsp_valid/rsp_ready        : response handshake (rsp_dat, rsp_err)
//   wbm_*                      : Wishbone classic initiator port
//   busy                       : high whenever the FSM is not IDLE
module wb_la_master
  import wb_la_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

  state_t state_q, state_d;
  logic   xfer;
  logic   in_bus;
  logic   to_expired;
  logic   err_term, ack_term, to_term, bus_done;

  assign xfer   = cmd_valid && cmd_ready;
  assign in_bus = (state_q == ST_BUS);

  // err beats ack; ack beats a timeout landing on the same cycle.
  assign err_term = in_bus && wbm_err_i;
  assign ack_term = in_bus && wbm_ack_i && !wbm_err_i;
  assign to_term  = in_bus && to_expired && !wbm_ack_i && !wbm_err_i;
  assign bus_done = err_term || ack_term || to_term;

  wb_timeout_ctr u_timeout_ctr (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (xfer),
    .enable  (in_bus),
    .limit   (TO_LIMIT),
    .expired (to_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (xfer)      state_d = ST_BUS;
      ST_BUS:  if (bus_done)  state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Bus fields and response payload; all cleared by reset so every output
  // reads zero straight out of reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (xfer) begin
        wbm_we_o  <= cmd_we;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        wbm_sel_o <= cmd_sel;
      end
      if (bus_done) begin
        rsp_err <= err_term || to_term;
        rsp_dat <= (ack_term && !wbm_we_o) ? wbm_dat_i : '0;
      end
    end
  end

  // Strobes come straight from the state register so an asynchronous
  // reset drops them without waiting for a clock edge.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign wbm_cyc_o = in_bus;
  assign wbm_stb_o = in_bus;
  assign rsp_valid = (state_q == ST_RESP);

endmodule

// File: tb/tb_wb_la_master.sv
// Directed bench for wb_la_master (TIMEOUT_CYCLES = 8).
module tb_wb_la_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  wb_la_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cyc",       wbm_cyc_o, 0);
    check("rst_stb",       wbm_stb_o, 0);
    check("rst_busy",      busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_adr",       wbm_adr_o, 0);
    #5 rst = 1'b0;
    step();

    // Write, ack after two wait states
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    check("wr_cyc",       wbm_cyc_o, 1);
    check("wr_stb",       wbm_stb_o, 1);
    check("wr_cmd_ready", cmd_ready, 0);
    check("wr_busy",      busy, 1);
    for (int i = 0; i < 3; i++) begin
      check("wr_we_held",  wbm_we_o, 1);
      check("wr_adr_held", wbm_adr_o, 32'h3000_0004);
      check("wr_dat_held", wbm_dat_o, 32'hDEAD_BEEF);
      check("wr_sel_held", wbm_sel_o, 4'hF);
      check("wr_cyc_held", wbm_cyc_o, 1);
      if (i == 2) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_0000;
      end
      step();
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    check("wr_cyc_drop",  wbm_cyc_o, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err",   rsp_err, 0);
    check("wr_rsp_dat",   rsp_dat, 0);
    consume();
    check("wr_rsp_gone",  rsp_valid, 0);
    check("wr_idle_rdy",  cmd_ready, 1);

    // Read, zero-wait ack, then a stalled response
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    check("rd_stb", wbm_stb_o, 1);
    check("rd_we",  wbm_we_o, 0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    step();
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_dat",   rsp_dat, 32'h1234_5678);
    check("rd_rsp_err",   rsp_err, 0);
    check("rd_cyc_drop",  wbm_cyc_o, 0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h5555_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_dat",   rsp_dat, 32'h1234_5678);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_no_cyc",    wbm_cyc_o, 0);
    end
    cmd_valid = 1'b0;
    consume();
    check("stall_rsp_gone", rsp_valid, 0);
    check("stall_no_xfer",  wbm_cyc_o, 0);
    check("stall_adr_kept", wbm_adr_o, 32'h3000_0000);

    // Timeout: no ack for 8 bus cycles
    issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
    wbm_dat_i = 32'hCAFE_F00D;
    for (int i = 0; i < 7; i++) begin
      check("to_cyc_held", wbm_cyc_o, 1);
      step();
    end
    check("to_cyc_last", wbm_cyc_o, 1);
    step();
    wbm_dat_i = '0;
    check("to_cyc_drop",  wbm_cyc_o, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err",   rsp_err, 1);
    check("to_rsp_dat",   rsp_dat, 0);
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    check("to_late_ack_err",   rsp_err, 1);
    check("to_late_ack_valid", rsp_valid, 1);
    consume();
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    check("idle_ack_no_cyc", wbm_cyc_o, 0);
    check("idle_ack_no_rsp", rsp_valid, 0);

    // ack and err together: err wins
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'h0BAD_0BAD;
    step();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    check("both_rsp_valid", rsp_valid, 1);
    check("both_rsp_err",   rsp_err, 1);
    check("both_rsp_dat",   rsp_dat, 0);
    consume();

    // err alone after one wait
    issue(1'b1, 32'h3000_0024, 32'h1111_2222, 4'h1);
    step();
    check("err_cyc_wait", wbm_cyc_o, 1);
    wbm_err_i = 1'b1;
    step();
    wbm_err_i = 1'b0;
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_dat", rsp_dat, 0);
    consume();

    // ack on the exact timeout cycle: normal completion
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) step();
    check("edge_cyc_still", wbm_cyc_o, 1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hA5A5_A5A5;
    step();
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    check("edge_rsp_valid", rsp_valid, 1);
    check("edge_rsp_err",   rsp_err, 0);
    check("edge_rsp_dat",   rsp_dat, 32'hA5A5_A5A5);
    consume();

    // Asynchronous reset in the middle of a bus cycle
    issue(1'b1, 32'h3000_0040, 32'h7777_8888, 4'hC);
    check("ar_cyc_before", wbm_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_cyc",       wbm_cyc_o, 0);
    check("ar_stb",       wbm_stb_o, 0);
    check("ar_busy",      busy, 0);
    check("ar_cmd_ready", cmd_ready, 1);
    check("ar_adr",       wbm_adr_o, 0);
    #1 rst = 1'b0;
    step();
    check("ar_no_rsp", rsp_valid, 0);
    step();
    check("ar_no_rsp2", rsp_valid, 0);
    issue(1'b0, 32'h3000_0044, 32'h0, 4'hF);
    check("ar_new_stb", wbm_stb_o, 1);
    check("ar_new_adr", wbm_adr_o, 32'h3000_0044);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0F0F_1234;
    step();
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    check("ar_new_rsp_valid", rsp_valid, 1);
    check("ar_new_rsp_dat",   rsp_dat, 32'h0F0F_1234);
    check("ar_new_rsp_err",   rsp_err, 0);
    consume();
    check("ar_new_idle", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
